// File: rtl/servo_pkg.sv
// Shared types and default widths for the servo PWM generator and its ramp sequencer.
// Combinational constants only: no latency and no backpressure.
// Downstream PWM logic sizes its duty compare from DEF_DUTY_W and DEF_DUTY_MAX.
package servo_pkg;

    localparam int DEF_DUTY_W   = 7;
    localparam int DEF_DUTY_MAX = 100;
    localparam int DWELL_W      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/servo_slew_step.sv
// One slew step: moves cur toward tgt by at most stp, never overshooting.
// Purely combinational: zero latency.
// No backpressure; the caller decides when to register nxt.
module servo_slew_step #(
    parameter int DUTY_W = 7,
    parameter int STEP_W = 4
) (
    input  logic [DUTY_W-1:0] cur,
    input  logic [DUTY_W-1:0] tgt,
    input  logic [STEP_W-1:0] stp,
    output logic [DUTY_W-1:0] nxt,
    output logic              at_target
);

    logic [DUTY_W-1:0] stp_d;
    logic [DUTY_W:0]   gap;

    assign stp_d = {{(DUTY_W-STEP_W){1'b0}}, stp};

    // The extra bit on gap keeps the distance compare free of wraparound.
    always_comb begin
        nxt = cur;
        gap = '0;
        if (tgt > cur) begin
            gap = {1'b0, tgt} - {1'b0, cur};
            nxt = (gap > {1'b0, stp_d}) ? (cur + stp_d) : tgt;
        end else if (cur > tgt) begin
            gap = {1'b0, cur} - {1'b0, tgt};
            nxt = (gap > {1'b0, stp_d}) ? (cur - stp_d) : tgt;
        end
    end

    assign at_target = (nxt == tgt);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Owns the servo duty register: slews toward commanded targets one step per PWM frame, then dwells.
// Latency: first duty change on the first frame_tick after acceptance; done pulses SETTLE_FRAMES ticks after reaching target.
// Backpressure: cmd_ready is low while busy, during abort, and in the done cycle.
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int DUTY_W        = DEF_DUTY_W,
    parameter int DUTY_MAX      = DEF_DUTY_MAX,
    parameter int PARK_DUTY     = 0,
    parameter int SETTLE_FRAMES = 8,
    parameter int STEP_W        = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic              abort,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done,
    output logic              clamped
);

    localparam logic [DUTY_W-1:0]  DMAX   = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0]  PARK   = DUTY_W'(PARK_DUTY);
    localparam logic [DWELL_W-1:0] SETTLE_N = DWELL_W'(SETTLE_FRAMES);

    state_t               state, state_n;
    logic [DUTY_W-1:0]    duty_q, duty_n, tgt_q, tgt_n, slew_nxt;
    logic [STEP_W-1:0]    stp_q, stp_n;
    logic [DWELL_W-1:0]   dwell_q, dwell_n;
    logic                 slew_at, hs;
    logic                 rdy_q, rdy_n, busy_q, done_q, done_n, clamped_q, clamped_n;

    servo_slew_step #(
        .DUTY_W (DUTY_W),
        .STEP_W (STEP_W)
    ) u_slew (
        .cur       (duty_q),
        .tgt       (tgt_q),
        .stp       (stp_q),
        .nxt       (slew_nxt),
        .at_target (slew_at)
    );

    // rdy_q is only set once we are in IDLE and past the done cycle.
    assign cmd_ready = rdy_q && !abort;
    assign hs        = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            duty_q    <= PARK;
            tgt_q     <= '0;
            stp_q     <= '0;
            dwell_q   <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state     <= state_n;
            duty_q    <= duty_n;
            tgt_q     <= tgt_n;
            stp_q     <= stp_n;
            dwell_q   <= dwell_n;
            rdy_q     <= rdy_n;
            busy_q    <= (state_n != IDLE);
            done_q    <= done_n;
            clamped_q <= clamped_n;
        end
    end

    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (hs) state_n = RAMP;
                RAMP:    if (frame_tick && slew_at) state_n = SETTLE;
                SETTLE:  if (frame_tick && dwell_q == DWELL_W'(1)) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Abort freezes every datapath register, so the duty seen by the PWM is held as-is.
    always_comb begin
        duty_n    = duty_q;
        tgt_n     = tgt_q;
        stp_n     = stp_q;
        dwell_n   = dwell_q;
        done_n    = 1'b0;
        clamped_n = 1'b0;
        if (!abort) begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        tgt_n     = (cmd_target > DMAX) ? DMAX : cmd_target;
                        stp_n     = (cmd_step == '0) ? STEP_W'(1) : cmd_step;
                        clamped_n = (cmd_target > DMAX);
                    end
                end
                RAMP: begin
                    if (frame_tick) begin
                        duty_n = slew_nxt;
                        if (slew_at) dwell_n = SETTLE_N;
                    end
                end
                SETTLE: begin
                    if (frame_tick) begin
                        dwell_n = dwell_q - DWELL_W'(1);
                        done_n  = (dwell_q == DWELL_W'(1));
                    end
                end
                default: ;
            endcase
        end
        rdy_n = (state_n == IDLE) && !done_n;
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign clamped  = clamped_q;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Bench for servo_ramp_ctrl: directed and random moves against an arithmetic duty-trajectory model.
module tb_servo_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] cmd_target = '0;
    logic [3:0] cmd_step = '0;
    logic       cmd_ready, busy, done, clamped;
    logic [6:0] duty_out;

    int checks = 0;
    int failures = 0;
    int m_duty = 0;
    int m_tgt = 0;
    int m_stp = 1;

    servo_ramp_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .abort      (abort),
        .duty_out   (duty_out),
        .busy       (busy),
        .done       (done),
        .clamped    (clamped)
    );

    always #5 clk = ~clk;

    function automatic int model_next(input int cur, input int tgt, input int stp);
        if (cur < tgt) return cur + (((tgt - cur) < stp) ? (tgt - cur) : stp);
        if (cur > tgt) return cur - (((cur - tgt) < stp) ? (cur - tgt) : stp);
        return cur;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Idle cycles between frames: duty must not move and no command may be taken while busy.
    task automatic gap_cycles();
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
            step();
            checks++;
            if (duty_out !== 7'(m_duty) || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL gap_hold duty=%0d ready=%b required duty=%0d ready=0", duty_out, cmd_ready, m_duty);
            end
        end
    endtask

    task automatic issue_cmd(input int target, input int stp_in);
        int n;
        bit exp_clamp;
        cmd_target = 7'(target);
        cmd_step   = 4'(stp_in);
        cmd_valid  = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout cmd_ready=%b required 1", cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        m_tgt = (target > 100) ? 100 : target;
        m_stp = (stp_in == 0) ? 1 : stp_in;
        exp_clamp = (target > 100);
        checks++;
        if (busy !== 1'b1 || clamped !== exp_clamp || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL accept busy=%b clamped=%b ready=%b required busy=1 clamped=%b ready=0",
                     busy, clamped, cmd_ready, exp_clamp);
        end
        step();
        checks++;
        if (clamped !== 1'b0 || duty_out !== 7'(m_duty)) begin
            failures++;
            $display("FAIL clamp_pulse clamped=%b duty=%0d required clamped=0 duty=%0d", clamped, duty_out, m_duty);
        end
    endtask

    task automatic ramp_and_settle(output int ramp_ticks);
        bit settled;
        int guard;
        settled = 1'b0;
        guard = 0;
        ramp_ticks = 0;
        while (!settled && guard < 300) begin
            gap_cycles();
            pulse_tick();
            guard++;
            if (m_duty != m_tgt) begin
                m_duty = model_next(m_duty, m_tgt, m_stp);
                ramp_ticks++;
            end
            settled = (m_duty == m_tgt);
            checks++;
            if (duty_out !== 7'(m_duty) || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL ramp duty=%0d busy=%b done=%b required duty=%0d busy=1 done=0",
                         duty_out, busy, done, m_duty);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            gap_cycles();
            pulse_tick();
            checks++;
            if (k < 8) begin
                if (busy !== 1'b1 || done !== 1'b0 || duty_out !== 7'(m_duty)) begin
                    failures++;
                    $display("FAIL settle k=%0d busy=%b done=%b duty=%0d required busy=1 done=0 duty=%0d",
                             k, busy, done, duty_out, m_duty);
                end
            end else if (busy !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b0 || duty_out !== 7'(m_duty)) begin
                failures++;
                $display("FAIL done busy=%b done=%b ready=%b duty=%0d required busy=0 done=1 ready=0 duty=%0d",
                         busy, done, cmd_ready, duty_out, m_duty);
            end
        end
        step();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_done done=%b ready=%b required done=0 ready=1", done, cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (duty_out !== 7'd0 || busy !== 1'b0 || done !== 1'b0 || clamped !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset duty=%0d busy=%b done=%b clamped=%b ready=%b required 0 0 0 0 0",
                     duty_out, busy, done, clamped, cmd_ready);
        end
        rst_n = 1'b1;
        step();
        m_duty = 0;
        checks++;
        if (cmd_ready !== 1'b1 || duty_out !== 7'd0) begin
            failures++;
            $display("FAIL reset_release ready=%b duty=%0d required ready=1 duty=0", cmd_ready, duty_out);
        end
    endtask

    task automatic test_ramp_up();
        int rt;
        issue_cmd(20, 5);
        ramp_and_settle(rt);
        checks++;
        if (rt != 4 || duty_out !== 7'd20) begin
            failures++;
            $display("FAIL ramp_up ticks=%0d duty=%0d required ticks=4 duty=20", rt, duty_out);
        end
    endtask

    task automatic test_ramp_down();
        int rt;
        issue_cmd(3, 6);
        ramp_and_settle(rt);
        checks++;
        if (rt != 3 || duty_out !== 7'd3) begin
            failures++;
            $display("FAIL ramp_down ticks=%0d duty=%0d required ticks=3 duty=3", rt, duty_out);
        end
    endtask

    task automatic test_clamp();
        int rt;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        m_duty = 0;
        issue_cmd(120, 0);
        ramp_and_settle(rt);
        checks++;
        if (rt != 100 || duty_out !== 7'd100) begin
            failures++;
            $display("FAIL clamp_ramp ticks=%0d duty=%0d required ticks=100 duty=100", rt, duty_out);
        end
    endtask

    task automatic test_abort();
        int rt;
        issue_cmd(40, 15);
        ramp_and_settle(rt);
        issue_cmd(80, 7);
        abort = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        cmd_valid = 1'b1;
        #1;
        checks++;
        if (duty_out !== 7'd40 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort duty=%0d busy=%b done=%b ready=%b required duty=40 busy=0 done=0 ready=0",
                     duty_out, busy, done, cmd_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle busy=%b done=%b required busy=0 done=0", busy, done);
        end
        abort = 1'b0;
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_release ready=%b required 1", cmd_ready);
        end
        pulse_tick();
        checks++;
        if (duty_out !== 7'd40 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_tick duty=%0d busy=%b required duty=40 busy=0", duty_out, busy);
        end
        issue_cmd(80, 7);
        ramp_and_settle(rt);
        checks++;
        if (rt != 6 || duty_out !== 7'd80) begin
            failures++;
            $display("FAIL after_abort ticks=%0d duty=%0d required ticks=6 duty=80", rt, duty_out);
        end
    endtask

    task automatic test_back_to_back();
        int rt;
        issue_cmd(10, 3);
        cmd_target = 7'd55;
        cmd_step   = 4'd9;
        cmd_valid  = 1'b1;
        ramp_and_settle(rt);
        issue_cmd(55, 9);
        ramp_and_settle(rt);
        checks++;
        if (rt != 5 || duty_out !== 7'd55) begin
            failures++;
            $display("FAIL back_to_back ticks=%0d duty=%0d required ticks=5 duty=55", rt, duty_out);
        end
    endtask

    task automatic test_random_moves();
        int rt;
        for (int i = 0; i < 6; i++) begin
            issue_cmd(int'($urandom_range(0, 127)), int'($urandom_range(0, 15)));
            ramp_and_settle(rt);
        end
    endtask

    task automatic test_async_reset();
        int rt;
        issue_cmd(90, 2);
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            if (m_duty != m_tgt) m_duty = model_next(m_duty, m_tgt, m_stp);
        end
        checks++;
        if (duty_out !== 7'(m_duty)) begin
            failures++;
            $display("FAIL pre_reset duty=%0d required %0d", duty_out, m_duty);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (duty_out !== 7'd0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset duty=%0d busy=%b ready=%b required 0 0 0", duty_out, busy, cmd_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        m_duty = 0;
        issue_cmd(5, 0);
        ramp_and_settle(rt);
        checks++;
        if (rt != 5 || duty_out !== 7'd5) begin
            failures++;
            $display("FAIL post_reset_move ticks=%0d duty=%0d required ticks=5 duty=5", rt, duty_out);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_random_moves();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_ramp_ctrl.md
Name: servo_ramp_ctrl

Overview:
Sequencer that owns the duty register of the servo PWM generator (100-step frame, duty 0..100).
- Accepts position commands over a valid/ready handshake.
- Slews duty toward each target at a bounded rate, one step per PWM frame.
- Holds the target for a settle dwell, then reports done.
- Duty changes only at frame boundaries, so the generator never sees a mid-frame update.

Parameters:
DUTY_W, 7, width of duty values
DUTY_MAX, 100, largest legal duty; larger targets are clamped to this
PARK_DUTY, 0, duty_out value after reset
SETTLE_FRAMES, 8, frames to hold at target before done; legal range 1..255
STEP_W, 4, width of per-frame slew step

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse from the PWM generator when its frame counter wraps 99->0
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted this cycle when both valid and ready are high
cmd_target  in  DUTY_W  target duty
cmd_step  in  STEP_W  max duty change per frame; 0 is treated as 1
abort  in  1  stop the current move and hold the present duty
duty_out  out  DUTY_W  duty to PWM generator
busy  out  1  high in RAMP or SETTLE
done  out  1  one-cycle pulse when a move completes
clamped  out  1  one-cycle pulse when an accepted target exceeded DUTY_MAX

Behaviour:
Reset (async assert, sync release):
- State IDLE, duty_out=PARK_DUTY.
- cmd_ready=0, busy=0, done=0, clamped=0.
- Target, step and dwell registers = 0.

States:
- IDLE: cmd_ready = !abort.
  - On handshake: latch tgt = min(cmd_target, DUTY_MAX) and stp = max(cmd_step, 1).
  - Pulse clamped the next cycle if cmd_target > DUTY_MAX.
  - Go to RAMP.
- RAMP: on frame_tick:
  - If duty_out < tgt: duty_out += min(stp, tgt - duty_out).
  - If duty_out > tgt: duty_out -= min(stp, duty_out - tgt).
  - Use an unsigned DUTY_W+1 difference. duty_out never overshoots and never wraps.
  - When the updated duty equals tgt: load dwell = SETTLE_FRAMES and go to SETTLE.
  - If tgt equals duty_out at acceptance, the first frame_tick in RAMP moves straight to SETTLE with no duty change.
- SETTLE: each frame_tick decrements dwell. On the tick where dwell goes 1->0: go to IDLE and pulse done for 1 cycle.
- abort (any state, level-sampled):
  - Next state IDLE, duty_out held, no done pulse.
  - abort wins over a same-cycle frame_tick; duty is not updated that cycle.
  - abort wins over cmd_valid in IDLE.

Other rules:
- cmd_valid while busy is ignored (cmd_ready=0). The requester must hold cmd_valid until cmd_ready is seen.
- done and a new handshake may not occur in the same cycle: cmd_ready rises the cycle after the return to IDLE.
- frame_tick in IDLE has no effect.
- duty_out changes only in the cycle after a frame_tick, or at reset.
- busy is registered and equals (state != IDLE).
- Latency: handshake -> first duty change at the first frame_tick after entering RAMP. The accept-cycle tick is not used.

Decomposition:
Shared package servo_pkg:
- state enum {IDLE, RAMP, SETTLE}.
- DUTY_W and DUTY_MAX defaults, shared with the PWM generator.

Sub-module servo_slew_step (combinational): inputs cur, tgt, stp; outputs next duty and at_target.

Everything else (FSM, dwell counter, handshake) is in servo_ramp_ctrl.

Test Plan:
- Reset with PARK_DUTY=0 -> duty_out=0, busy=0, cmd_ready=1 once rst_n rises and abort=0.
- Move 0->20 with step 5 -> duty 5,10,15,20 on 4 successive frame_ticks; then 8 ticks later a done pulse; busy is high from the accept cycle until the done cycle.
- Move 20->3 with step 6 -> duty 14, 8, 3; no undershoot below 3.
- Target 120, step 0 -> clamped pulse; tgt=100; duty rises by 1 per frame, reaching 100 after 100 ticks; then a done pulse.
- abort in RAMP at duty 40 (target 80) together with a frame_tick -> duty stays 40, IDLE, no done; next command accepted.
- cmd_valid held high during SETTLE -> not accepted until the cycle after done; rst_n low mid-RAMP -> duty_out=PARK_DUTY immediately (async).
